// File: rtl/skullfet_inv_checker.sv
`default_nettype none
// ============================================================================
// Module   : skullfet_inv_checker
// Brief    : Self-test sequencer for a single SkullFET inverter cell. Drives
//            the inverter input, synchronises its output, checks for correct
//            inversion, counts passes/fails and records response latency.
// Revision : 1.0 - initial release
// ============================================================================
module skullfet_inv_checker #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255,
    parameter int HOLD        = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n,
    input  logic             start_i,
    input  logic [7:0]       num_toggles_i,
    input  logic             resp_i,
    output logic             stim_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] fail_cnt_o,
    output logic [7:0]       last_delay_o,
    output logic             err_o
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_DRIVE = 3'd1;
    localparam logic [2:0] c_ST_WAIT  = 3'd2;
    localparam logic [2:0] c_ST_GAP   = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    localparam int              c_HOLD_W   = $clog2(HOLD + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD = c_HOLD_W'(HOLD);
    localparam logic [7:0]      c_TIMEOUT  = 8'(TIMEOUT);
    // The first WAIT cycle in which the synchroniser output can reflect the
    // new stimulus; earlier samples are stale pre-toggle data.
    localparam logic [7:0]      c_MIN_WAIT = 8'(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [2:0]             r_state;
    logic [2:0]             w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_stim;
    logic [7:0]             r_rem;
    logic [7:0]             r_wcnt;
    logic [c_HOLD_W-1:0]    r_gcnt;
    logic [CNT_W-1:0]       r_pass_cnt;
    logic [CNT_W-1:0]       r_fail_cnt;
    logic [7:0]             r_last_delay;
    logic                   r_err;

    logic w_resp_s;
    logic w_match;
    logic w_timeout;
    logic w_gap_end;

    assign w_resp_s  = r_sync[SYNC_STAGES-1];
    assign w_match   = (r_wcnt >= c_MIN_WAIT) && (w_resp_s == ~r_stim);
    assign w_timeout = (r_wcnt == c_TIMEOUT);
    assign w_gap_end = (r_gcnt == c_HOLD);

    // Multi-flop synchroniser for the asynchronous inverter output
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], resp_i};
        end
    end

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start_i) begin
                    w_state_nxt = (num_toggles_i == 8'd0) ? c_ST_DONE : c_ST_DRIVE;
                end
            end
            c_ST_DRIVE: w_state_nxt = c_ST_WAIT;
            c_ST_WAIT: begin
                if (w_match || w_timeout) begin
                    w_state_nxt = c_ST_GAP;
                end
            end
            c_ST_GAP: begin
                if (w_gap_end) begin
                    w_state_nxt = (r_rem == 8'd1) ? c_ST_DONE : c_ST_DRIVE;
                end
            end
            c_ST_DONE: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Datapath: stimulus, wait/gap counters and result registers
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            r_stim       <= 1'b0;
            r_rem        <= 8'd0;
            r_wcnt       <= 8'd0;
            r_gcnt       <= '0;
            r_pass_cnt   <= '0;
            r_fail_cnt   <= '0;
            r_last_delay <= 8'd0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start_i) begin
                        r_rem        <= num_toggles_i;
                        r_pass_cnt   <= '0;
                        r_fail_cnt   <= '0;
                        r_last_delay <= 8'd0;
                        r_err        <= 1'b0;
                    end
                end
                c_ST_DRIVE: begin
                    r_stim <= ~r_stim;
                    r_wcnt <= 8'd1;
                end
                c_ST_WAIT: begin
                    if (w_match) begin
                        r_last_delay <= r_wcnt;
                        r_gcnt       <= c_HOLD_W'(1);
                        if (r_pass_cnt != c_CNT_MAX) begin
                            r_pass_cnt <= r_pass_cnt + 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_err  <= 1'b1;
                        r_gcnt <= c_HOLD_W'(1);
                        if (r_fail_cnt != c_CNT_MAX) begin
                            r_fail_cnt <= r_fail_cnt + 1'b1;
                        end
                    end else begin
                        r_wcnt <= r_wcnt + 8'd1;
                    end
                end
                c_ST_GAP: begin
                    if (w_gap_end) begin
                        r_rem <= r_rem - 8'd1;
                    end else begin
                        r_gcnt <= r_gcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stim_o       = r_stim;
    assign busy_o       = (r_state == c_ST_DRIVE) || (r_state == c_ST_WAIT) ||
                          (r_state == c_ST_GAP);
    assign done_o       = (r_state == c_ST_DONE);
    assign pass_cnt_o   = r_pass_cnt;
    assign fail_cnt_o   = r_fail_cnt;
    assign last_delay_o = r_last_delay;
    assign err_o        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_skullfet_inv_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_skullfet_inv_checker
// Brief    : Self-checking bench for skullfet_inv_checker. A behavioural
//            inverter (ideal, delayed or stuck) feeds the DUT; expected run
//            results come from a per-toggle outcome model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_skullfet_inv_checker;

    localparam int CNT_W   = 16;
    localparam int SYNC    = 2;
    localparam int TIMEOUT = 255;
    localparam int HOLD    = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             r_start;
    logic [7:0]       r_num;
    logic             w_resp;
    logic             w_stim;
    logic             w_busy;
    logic             w_done;
    logic [CNT_W-1:0] w_pass;
    logic [CNT_W-1:0] w_fail;
    logic [7:0]       w_last;
    logic             w_err;

    int checks = 0;
    int errors = 0;

    // Inverter model controls
    bit        mode_stuck = 1'b0;
    logic      stuck_val  = 1'b0;
    int        delay_d    = 0;
    logic [15:0] hist     = '0;
    logic      model_stim = 1'b0;

    skullfet_inv_checker #(
        .CNT_W(CNT_W), .SYNC_STAGES(SYNC), .TIMEOUT(TIMEOUT), .HOLD(HOLD)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_n     (rst_n),
        .start_i      (r_start),
        .num_toggles_i(r_num),
        .resp_i       (w_resp),
        .stim_o       (w_stim),
        .busy_o       (w_busy),
        .done_o       (w_done),
        .pass_cnt_o   (w_pass),
        .fail_cnt_o   (w_fail),
        .last_delay_o (w_last),
        .err_o        (w_err)
    );

    always #5 clk = ~clk;

    // Stimulus history, used to delay the inverter response by whole cycles
    always @(posedge clk) hist <= {hist[14:0], w_stim};

    assign w_resp = mode_stuck ? stuck_val :
                    (delay_d == 0) ? ~w_stim : ~hist[delay_d-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic settle();
        repeat (12) @(negedge clk);
    endtask

    // Launch a run of n toggles and compare it against the outcome model.
    task automatic run_and_check(input string tag, input int n, input bit noisy_start);
        int   exp_pass, exp_fail, exp_last, exp_cyc, w, cyc, busy_bad;
        bit   exp_err, ok;
        logic s;
        exp_pass = 0; exp_fail = 0; exp_last = 0; exp_err = 1'b0;
        exp_cyc  = 1; busy_bad = 0;
        s = model_stim;
        for (int i = 0; i < n; i++) begin
            s  = ~s;
            ok = mode_stuck ? (stuck_val != s) : 1'b1;
            w  = ok ? (SYNC + 1 + (mode_stuck ? 0 : delay_d)) : TIMEOUT;
            if (w > TIMEOUT) begin
                ok = 1'b0;
                w  = TIMEOUT;
            end
            if (ok) begin
                exp_pass++;
                exp_last = w;
            end else begin
                exp_fail++;
                exp_err = 1'b1;
            end
            exp_cyc += 1 + w + HOLD;
        end

        @(negedge clk);
        r_start = 1'b1;
        r_num   = 8'(n);
        @(negedge clk);
        r_start = 1'b0;
        cyc = 1;
        while (!w_done && cyc < exp_cyc + 100) begin
            if (w_busy !== 1'b1) busy_bad++;
            if (noisy_start) begin
                r_start = 1'($urandom_range(0, 1));
                r_num   = 8'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        r_start = 1'b0;
        check({tag, " cycles"}, cyc, exp_cyc);
        check({tag, " done"}, w_done, 1'b1);
        check({tag, " busy@done"}, w_busy, 1'b0);
        check({tag, " busy_in_run"}, busy_bad, 0);
        @(negedge clk);
        check({tag, " done_pulse"}, w_done, 1'b0);
        check({tag, " pass"}, w_pass, exp_pass);
        check({tag, " fail"}, w_fail, exp_fail);
        check({tag, " last"}, w_last, exp_last);
        check({tag, " err"}, w_err, exp_err);
        check({tag, " stim"}, w_stim, s);
        model_stim = s;
    endtask

    initial begin
        int dones;
        rst_n   = 1'b0;
        r_start = 1'b0;
        r_num   = 8'd0;
        repeat (3) @(negedge clk);
        check("rst stim", w_stim, 1'b0);
        check("rst busy", w_busy, 1'b0);
        check("rst done", w_done, 1'b0);
        check("rst pass", w_pass, 0);
        check("rst fail", w_fail, 0);
        check("rst last", w_last, 0);
        check("rst err", w_err, 1'b0);
        rst_n = 1'b1;
        settle();

        // Ideal inverter, four toggles
        mode_stuck = 1'b0; delay_d = 0;
        run_and_check("ideal4", 4, 1'b0);

        // Five-cycle inverter delay
        delay_d = 5; settle();
        run_and_check("delay5", 2, 1'b0);

        // Output stuck high
        mode_stuck = 1'b1; stuck_val = 1'b1; settle();
        run_and_check("stuck1", 3, 1'b0);

        // Zero-length run
        mode_stuck = 1'b0; delay_d = 0; settle();
        run_and_check("zero", 0, 1'b0);

        // Reset during the WAIT of toggle 2
        settle();
        @(negedge clk);
        r_start = 1'b1;
        r_num   = 8'd3;
        @(negedge clk);
        r_start = 1'b0;
        repeat (9) @(negedge clk);
        check("mid pass_before_rst", w_pass, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid stim", w_stim, 1'b0);
        check("mid busy", w_busy, 1'b0);
        check("mid done", w_done, 1'b0);
        check("mid pass", w_pass, 0);
        check("mid err", w_err, 1'b0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (w_done) dones++;
        end
        check("mid no_done", dones, 0);
        model_stim = 1'b0;
        run_and_check("after_rst", 2, 1'b0);

        // Start pulses while busy must be ignored
        settle();
        run_and_check("noisy", 3, 1'b1);

        // Randomised runs
        for (int k = 0; k < 6; k++) begin
            mode_stuck = ($urandom_range(0, 2) == 0);
            stuck_val  = 1'($urandom_range(0, 1));
            delay_d    = $urandom_range(0, 6);
            settle();
            run_and_check($sformatf("rand%0d", k), $urandom_range(1, 5), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/skullfet_inv_checker.md
Name: skullfet_inv_checker

Overview:
- Self-test sequencer that sits on both sides of a single skullfet_inverter cell in the user project wrapper.
- Upstream, it drives the inverter input pad path (stim_o).
- Downstream, it consumes the inverter output (resp_i) through a synchroniser and checks for correct inversion.
- It counts passes and fails and measures round-trip response latency in clock cycles, so silicon bring-up can characterise the SkullFET cell from the logic analyser or GPIO.

Parameters:
- CNT_W, 16, width of the pass/fail counters.
- SYNC_STAGES, 2, number of flip-flop synchroniser stages on resp_i (minimum 2).
- TIMEOUT, 255, maximum WAIT cycles before a toggle is declared failed (1..255).
- HOLD, 4, GAP cycles stim_o is held stable after each check (minimum 1).

Ports:
- wb_clk_i  input  1  sole clock, rising edge.
- wb_rst_n  input  1  reset, synchronous, active-low.
- start_i  input  1  single-cycle request to begin a run; only accepted in IDLE.
- num_toggles_i  input  8  number of stimulus toggles in the run; sampled on an accepted start.
- resp_i  input  1  inverter output; asynchronous to wb_clk_i.
- stim_o  output  1  inverter input drive; registered.
- busy_o  output  1  high from the cycle after an accepted start until DONE.
- done_o  output  1  one-cycle pulse at the end of a run.
- pass_cnt_o  output  CNT_W  toggles whose response matched.
- fail_cnt_o  output  CNT_W  toggles that timed out.
- last_delay_o  output  8  WAIT-cycle index at which the most recent match was seen.
- err_o  output  1  sticky; set on any fail, cleared by reset or an accepted start.

Behaviour:
- Reset (wb_rst_n low at a rising edge):
  - state=IDLE.
  - stim_o, busy_o, done_o, err_o = 0; all counters and last_delay_o = 0; synchroniser flops = 0.
  - Reset asserted mid-run aborts the run immediately with no done_o pulse.
- Synchroniser: resp_i passes through SYNC_STAGES flops; only the last stage (resp_s) is used.
- IDLE:
  - start_i=1 latches num_toggles_i into rem.
  - It clears pass_cnt, fail_cnt, last_delay and err.
  - If num_toggles_i == 0, the next state is DONE; otherwise it is DRIVE.
  - start_i in any other state is ignored and does not re-latch.
- DRIVE: one cycle. It inverts stim_o, sets wcnt=1 and goes to WAIT.
- WAIT: wcnt is a 1-based index of cycles spent in WAIT (1 in the first WAIT cycle).
  - If resp_s == ~stim_o: last_delay_o=wcnt, pass_cnt++, go to GAP.
  - Else if wcnt == TIMEOUT: fail_cnt++, err_o=1, go to GAP.
  - Else: wcnt++.
  - Match takes priority over timeout in the same cycle.
  - With a zero-delay inverter and SYNC_STAGES=2, the match is seen at wcnt=3 (SYNC_STAGES+1).
  - An inverter delay of d cycles gives last_delay = SYNC_STAGES+1+d.
- GAP: stay for exactly HOLD cycles with stim_o unchanged, then rem--.
  - If rem becomes 0, go to DONE; otherwise go to DRIVE.
- DONE: done_o=1 for this single cycle, busy_o=0, then go to IDLE.
  - stim_o keeps its final value and is not returned to 0.
- Counters saturate at all-ones and do not wrap.
- busy_o is asserted in DRIVE, WAIT and GAP, and is low in IDLE and DONE.
- Outputs keep their values after DONE until the next accepted start or reset.
- Per-toggle cycle count with no timeout: 1 (DRIVE) + wcnt_at_match + HOLD.

Test Plan:
- Ideal inverter model (resp_i = ~stim_o, zero delay), num_toggles=4, default parameters -> pass_cnt=4, fail_cnt=0, last_delay=3, err=0, stim_o ends at 0, done_o pulses once; start to done_o = 1+4*(1+3+4)+1 cycles.
- Inverter model with 5-cycle delay, num_toggles=2 -> pass_cnt=2, last_delay=8, fail_cnt=0.
- resp_i stuck at 1, num_toggles=3 -> first toggle (0 to 1) times out, second (back to 0) matches at wcnt=3, third times out; fail_cnt=2, pass_cnt=1, err=1, last_delay=3.
- num_toggles=0 -> no stim_o change, busy_o never high, done_o on the second cycle after start; counters 0.
- Reset asserted during the WAIT of toggle 2 -> next cycle state IDLE, stim_o=0, counters 0, no done_o pulse; a new start then runs normally.
- start_i pulsed repeatedly while busy with different num_toggles_i -> ignored; the run completes with the originally latched count.
